// File: rtl/fp_dispatch_pkg.sv
// fp_dispatch_pkg: shared constants for the FP adder operand dispatcher.
//   W_DEF / NCH_DEF : default operand width and path count
//   PATH_0..PATH_2  : path indices, same encoding as the EData class field
//   lvl_w()         : occupancy counter width for a FIFO of a given depth
package fp_dispatch_pkg;

    localparam int W_DEF   = 37;
    localparam int NCH_DEF = 3;

    localparam int PATH_0 = 0;
    localparam int PATH_1 = 1;
    localparam int PATH_2 = 2;

    // level must represent 0..depth inclusive, hence one bit above the
    // pointer width
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fp_operand_dispatch_fifo.sv
// dispatch_fifo: single-channel synchronous FIFO holding one {A,B} pair
// per entry.
//   clk, rst   : clock, async active-high reset (pointers and count only)
//   push, din  : write request and data; honoured when not full or popping
//   pop, dout  : read request and head data; pop on empty is ignored
//   full, empty, level : occupancy status, level counts 0..DEPTH
module dispatch_fifo #(
    parameter int DW    = 74,
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so full does not block
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: stale entries are never visible while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_operand_dispatch.sv
// fp_operand_dispatch: buffered router from operand preparation to the
// per-class FP adder paths. Each accepted (A,B) pair goes into the FIFO of
// the selected path; every path drains independently.
//   in_valid/in_ready/in_a/in_b/in_sel : upstream pair handshake
//   out_valid/out_ready/out_a/out_b    : per-path head, W-bit slices per path
//   level      : per-path occupancy, LW-bit slices
//   drop_pulse : one cycle after a pair with an out-of-range select is eaten
//   drop_cnt   : saturating count of such pairs
module fp_operand_dispatch
    import fp_dispatch_pkg::*;
#(
    parameter int  W     = W_DEF,
    parameter int  NCH   = NCH_DEF,
    parameter int  SELW  = 2,
    parameter int  DEPTH = 4,
    parameter int  CNTW  = 8,
    localparam int LW    = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [SELW-1:0]   in_sel,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*W-1:0]  out_a,
    output logic [NCH*W-1:0]  out_b,
    output logic [NCH*LW-1:0] level,
    output logic              drop_pulse,
    output logic [CNTW-1:0]   drop_cnt
);
    logic           legal;
    logic           drop;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;

    assign legal = (int'(in_sel) < NCH);

    // illegal selects are always accepted so they cannot wedge the input
    assign in_ready = !legal || |(hit & (~full | pop));
    assign drop     = in_valid && !legal;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [2*W-1:0] head;

        assign hit[i]  = legal && (in_sel == SELW'(i));
        assign pop[i]  = !empty[i] && out_ready[i];
        assign push[i] = in_valid && hit[i] && (!full[i] || pop[i]);

        dispatch_fifo #(
            .DW    (2*W),
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   ({in_a, in_b}),
            .pop   (pop[i]),
            .dout  (head),
            .full  (full[i]),
            .empty (empty[i]),
            .level (level[i*LW +: LW])
        );

        // idle paths present zeros rather than stale storage
        assign out_valid[i]     = !empty[i];
        assign out_a[i*W +: W]  = empty[i] ? '0 : head[2*W-1:W];
        assign out_b[i*W +: W]  = empty[i] ? '0 : head[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fp_operand_dispatch.sv
// tb_fp_operand_dispatch: queue-based reference model compared against the
// DUT every falling edge, plus directed scenarios with literal expectations.
module tb_fp_operand_dispatch;
    import fp_dispatch_pkg::*;

    localparam int W     = 37;
    localparam int NCH   = 3;
    localparam int SELW  = 2;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
    localparam int LW    = 3;

    typedef logic [2*W-1:0] pair_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [SELW-1:0]   in_sel;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*W-1:0]  out_a;
    logic [NCH*W-1:0]  out_b;
    logic [NCH*LW-1:0] level;
    logic              drop_pulse;
    logic [CNTW-1:0]   drop_cnt;

    int checks = 0;
    int passes = 0;

    fp_operand_dispatch #(
        .W(W), .NCH(NCH), .SELW(SELW), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .level      (level),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    pair_t q [NCH][$];
    bit    m_dp;
    int    m_cnt;

    function automatic bit m_ready();
        if (int'(in_sel) >= NCH) return 1'b1;
        return (q[in_sel].size() < DEPTH) ||
               (q[in_sel].size() > 0 && out_ready[in_sel]);
    endfunction

    // pops first: afterwards "room left" equals the pre-edge ready rule
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
            m_dp  <= 1'b0;
            m_cnt <= 0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (out_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (in_valid && int'(in_sel) < NCH && q[in_sel].size() < DEPTH)
                q[in_sel].push_back({in_a, in_b});
            m_dp <= in_valid && (int'(in_sel) >= NCH);
            if (in_valid && int'(in_sel) >= NCH && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            pair_t h;
            h = (q[i].size() > 0) ? q[i][0] : '0;
            chk($sformatf("ch%0d valid", i), out_valid[i], q[i].size() > 0);
            chk($sformatf("ch%0d a", i), out_a[i*W +: W], h[2*W-1:W]);
            chk($sformatf("ch%0d b", i), out_b[i*W +: W], h[W-1:0]);
            chk($sformatf("ch%0d level", i), level[i*LW +: LW], q[i].size());
        end
        chk("in_ready", in_ready, m_ready());
        chk("drop_pulse", drop_pulse, m_dp);
        chk("drop_cnt", drop_cnt, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [SELW-1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        in_sel = s; in_a = a; in_b = b; in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        $display("FAIL send timeout: sel %0d never accepted, required accept within 20 cycles", s);
        in_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = '0;
        #1 rst = 1'b1;
        cyc(2);
        chk("rst out_valid", out_valid, 3'b000);
        chk("rst level", level, 9'd0);
        chk("rst drop_cnt", drop_cnt, 8'd0);
        @(negedge clk); rst = 1'b0;
        cyc(1);

        // first push to path 1
        send(SELW'(PATH_1), 37'h0_0000_0001, 37'h1F_FFFF_FFFF);
        chk("t1 out_valid", out_valid, 3'b010);
        chk("t1 a1", out_a[W +: W], 37'h1);
        chk("t1 b1", out_b[W +: W], 37'h1F_FFFF_FFFF);
        chk("t1 a0", out_a[0 +: W], 37'h0);
        chk("t1 b2", out_b[2*W +: W], 37'h0);
        chk("t1 level1", level[LW +: LW], 3'd1);
        out_ready = 3'b010; cyc(1); out_ready = '0;
        chk("t1 drained", out_valid, 3'b000);

        // fill path 0, fifth pair refused
        for (int k = 1; k <= 4; k++) send(SELW'(PATH_0), W'(k), W'(k + 100));
        in_sel = SELW'(PATH_0); in_a = 37'd5; in_valid = 1'b1;
        @(negedge clk);
        chk("t2 full ready", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            chk("t2 head", out_a[0 +: W], W'(k));
            cyc(1);
        end
        chk("t2 empty", out_valid[0], 1'b0);
        out_ready = '0;

        // push into a full path while it pops
        for (int k = 5; k <= 8; k++) send(SELW'(PATH_0), W'(k), W'(k));
        out_ready = 3'b001; in_sel = SELW'(PATH_0); in_a = 37'd9; in_b = 37'd9; in_valid = 1'b1;
        @(negedge clk);
        chk("t3 full+pop ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = '0;
        chk("t3 level", level[0 +: LW], 3'd4);
        out_ready = 3'b001;
        for (int k = 6; k <= 9; k++) begin
            chk("t3 head", out_a[0 +: W], W'(k));
            cyc(1);
        end
        chk("t3 empty", out_valid[0], 1'b0);
        out_ready = '0;

        // illegal select
        in_sel = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        chk("t4 ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4 pulse", drop_pulse, 1'b1);
        chk("t4 cnt", drop_cnt, 8'd1);
        chk("t4 levels", level, 9'd0);
        cyc(1);
        chk("t4 pulse off", drop_pulse, 1'b0);
        in_valid = 1'b1;
        cyc(300);
        in_valid = 1'b0;
        chk("t4 saturate", drop_cnt, 8'd255);

        // path 2 stalled, path 0 streams
        for (int k = 0; k < 4; k++) send(SELW'(PATH_2), W'(40 + k), W'(k));
        out_ready = 3'b001;
        for (int k = 0; k < 6; k++) begin
            in_sel = SELW'(PATH_0); in_a = W'(20 + k); in_b = W'(k); in_valid = 1'b1;
            @(negedge clk);
            chk("t5 ch0 ready", in_ready, 1'b1);
            in_sel = SELW'(PATH_2);
            #1 chk("t5 ch2 ready", in_ready, 1'b0);
            in_sel = SELW'(PATH_0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc(1);
        chk("t5 ch0 level", level[0 +: LW], 3'd0);
        chk("t5 ch2 level", level[2*LW +: LW], 3'd4);

        // async reset between edges
        out_ready = '0; in_sel = SELW'(PATH_0); in_a = 37'd50; in_valid = 1'b1;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("t6 out_valid", out_valid, 3'b000);
        chk("t6 level", level, 9'd0);
        chk("t6 drop_cnt", drop_cnt, 8'd0);
        chk("t6 out_a", out_a, '0);
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        cyc(1);
        send(SELW'(PATH_1), 37'd77, 37'd78);
        chk("t6 post valid", out_valid, 3'b010);
        chk("t6 post a", out_a[W +: W], 37'd77);
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
